// File: rtl/seven_seg_scan_mux.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Scans digit 0..3 with a blanking gap per slot and optional leading-zero suppression.
module seven_seg_scan_mux #(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] digits,
    input  logic [3:0]  dp,
    input  logic        blank_lz,
    output logic [3:0]  io_7seg_select,
    output logic [7:0]  io_7seg,
    output logic        scan_tick
);

    localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [0:0] {StIdle, StActive} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   sh_digits;
    logic [3:0]    sh_dp;
    logic          sh_blank_lz;

    logic          load;
    logic          wrap;
    logic          in_blank;
    logic [15:0]   eff_digits;
    logic [3:0]    eff_dp;
    logic          eff_blank_lz;
    logic [3:0]    nibble;
    logic [6:0]    pattern;
    logic          lz_blank;
    logic [3:0]    sel_next;
    logic [7:0]    seg_next;

    always_comb begin
        load     = (state == StActive) && (cnt == '0) && (idx == 2'd0);
        wrap     = (cnt == CW'(REFRESH_DIV - 1));
        in_blank = (cnt < CW'(BLANK_CYCLES));

        // Bypass the shadow on the load cycle so a zero-length blank gap still shows fresh data
        eff_digits   = load ? digits   : sh_digits;
        eff_dp       = load ? dp       : sh_dp;
        eff_blank_lz = load ? blank_lz : sh_blank_lz;

        nibble = eff_digits[{idx, 2'b00} +: 4];

        pattern = 7'b0000001;
        case (nibble)
            4'd0:    pattern = 7'b1111110;
            4'd1:    pattern = 7'b0110000;
            4'd2:    pattern = 7'b1101101;
            4'd3:    pattern = 7'b1111001;
            4'd4:    pattern = 7'b0110011;
            4'd5:    pattern = 7'b1011011;
            4'd6:    pattern = 7'b1011111;
            4'd7:    pattern = 7'b1110000;
            4'd8:    pattern = 7'b1111111;
            4'd9:    pattern = 7'b1111011;
            default: pattern = 7'b0000001;
        endcase

        lz_blank = 1'b0;
        unique case (idx)
            2'd3: lz_blank = (eff_digits[15:12] == 4'd0);
            2'd2: lz_blank = (eff_digits[15:8] == 8'd0);
            2'd1: lz_blank = (eff_digits[15:4] == 12'd0);
            2'd0: lz_blank = 1'b0;
        endcase
        lz_blank = lz_blank & eff_blank_lz;

        sel_next = ~(4'b0001 << idx);
        seg_next = {~eff_dp[idx], lz_blank ? 7'h7F : ~pattern};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= StActive;
            cnt            <= '0;
            idx            <= 2'd0;
            sh_digits      <= 16'd0;
            sh_dp          <= 4'd0;
            sh_blank_lz    <= 1'b0;
            io_7seg_select <= 4'hF;
            io_7seg        <= 8'hFF;
            scan_tick      <= 1'b0;
        end else begin
            io_7seg_select <= 4'hF;
            io_7seg        <= 8'hFF;
            scan_tick      <= 1'b0;
            case (state)
                StIdle: begin
                    cnt <= '0;
                    idx <= 2'd0;
                    if (enable) state <= StActive;
                end
                StActive: begin
                    if (load) begin
                        sh_digits   <= digits;
                        sh_dp       <= dp;
                        sh_blank_lz <= blank_lz;
                    end
                    if (!in_blank) begin
                        io_7seg_select <= sel_next;
                        io_7seg        <= seg_next;
                    end
                    if (!enable) begin
                        state <= StIdle;
                        cnt   <= '0;
                        idx   <= 2'd0;
                    end else if (wrap) begin
                        cnt       <= '0;
                        idx       <= idx + 2'd1;
                        scan_tick <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Directed bench for seven_seg_scan_mux with REFRESH_DIV = 8, BLANK_CYCLES = 2.
module tb_seven_seg_scan_mux;

    localparam int RD = 8;
    localparam int BC = 2;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        blank_lz;
    logic [3:0]  io_7seg_select;
    logic [7:0]  io_7seg;
    logic        scan_tick;

    int checks = 0;
    int errors = 0;

    // Expected segment byte per digit index for the scan in progress
    logic [7:0] exp_tab [4];

    seven_seg_scan_mux #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .digits         (digits),
        .dp             (dp),
        .blank_lz       (blank_lz),
        .io_7seg_select (io_7seg_select),
        .io_7seg        (io_7seg),
        .scan_tick      (scan_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int cyc, input logic [3:0] sel_e,
                       input logic [7:0] seg_e, input logic tick_e);
        checks++;
        assert (io_7seg_select === sel_e) else begin
            errors++;
            $error("FAIL %s cyc=%0d select got %b want %b", tag, cyc, io_7seg_select, sel_e);
        end
        checks++;
        assert (io_7seg === seg_e) else begin
            errors++;
            $error("FAIL %s cyc=%0d seg got %h want %h", tag, cyc, io_7seg, seg_e);
        end
        checks++;
        assert (scan_tick === tick_e) else begin
            errors++;
            $error("FAIL %s cyc=%0d tick got %b want %b", tag, cyc, scan_tick, tick_e);
        end
    endtask

    // n counts cycles from the load cycle (cnt=0, idx=0) at 'base'; outputs lag cnt by one.
    task automatic scan_check(input string tag, input int base, input int from, input int to);
        int p;
        int i;
        for (int n = from; n <= to; n++) begin
            step();
            p = (n - 1) % RD;
            i = ((n - 1) / RD) % 4;
            if (p < BC)
                chk(tag, base + n, 4'hF, 8'hFF, (n % RD == 0));
            else
                chk(tag, base + n, ~(4'b0001 << i), exp_tab[i], (n % RD == 0));
        end
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b1;
        digits   = 16'h1234;
        dp       = 4'b0000;
        blank_lz = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_state", 0, 4'hF, 8'hFF, 1'b0);

        // 1234: idx0 "4", idx1 "3", idx2 "2", idx3 "1"
        exp_tab[0] = 8'hCC;
        exp_tab[1] = 8'h86;
        exp_tab[2] = 8'h92;
        exp_tab[3] = 8'hCF;
        scan_check("scan_1234", 0, 1, 40);

        // Cycle 40 is idx=1: new digits must not tear the current scan
        digits = 16'h9999;
        scan_check("no_tear", 0, 41, 64);
        exp_tab[0] = 8'h84;
        exp_tab[1] = 8'h84;
        exp_tab[2] = 8'h84;
        exp_tab[3] = 8'h84;
        scan_check("scan_9999", 0, 65, 96);

        // Leading-zero suppression with a dp on a blanked digit
        digits   = 16'h0050;
        blank_lz = 1'b1;
        dp       = 4'b0100;
        exp_tab[0] = 8'h81;
        exp_tab[1] = 8'hA4;
        exp_tab[2] = 8'h7F;
        exp_tab[3] = 8'hFF;
        scan_check("blank_lz", 0, 97, 128);

        // Nibble B renders as a dash
        digits   = 16'h000B;
        blank_lz = 1'b0;
        dp       = 4'b0000;
        exp_tab[0] = 8'hFE;
        exp_tab[1] = 8'h81;
        exp_tab[2] = 8'h81;
        exp_tab[3] = 8'h81;
        scan_check("dash", 0, 129, 140);

        // Drop enable mid-slot (cnt=4, idx=1) for cycles 140..144
        enable = 1'b0;
        digits = 16'h0007;
        step();
        chk("en_drop_last", 141, 4'b1101, 8'h81, 1'b0);
        for (int c = 142; c <= 145; c++) begin
            step();
            chk("en_dark", c, 4'hF, 8'hFF, 1'b0);
        end
        enable = 1'b1;
        step();
        chk("reenable_dark", 146, 4'hF, 8'hFF, 1'b0);
        exp_tab[0] = 8'h8F;
        scan_check("reenable", 146, 1, 13);

        // Cycle 159 has cnt=5, idx=1: pulse reset
        reset = 1'b1;
        step();
        chk("mid_reset", 160, 4'hF, 8'hFF, 1'b0);
        reset = 1'b0;
        scan_check("after_reset", 160, 1, 32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
